// File: rtl/tank_pkg.sv
// Shared types and screen limits for the tank game blocks, plus small
// position/velocity helpers used by the bullet datapath.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } bullet_state_t;

    localparam logic [9:0] SCREEN_X_MAX = 10'd639;
    localparam logic [9:0] SCREEN_Y_MAX = 10'd479;

    // Two's complement negation of a 10-bit velocity.
    function automatic logic [9:0] negate(input logic [9:0] v);
        return ~v + 10'd1;
    endfunction

    // Pin an 11-bit signed candidate coordinate into 0..max.
    function automatic logic [9:0] clamp_pos(input logic signed [10:0] p,
                                             input logic [9:0]         max);
        logic [9:0] r;
        if (p < 11'sd0) begin
            r = 10'd0;
        end else if (p > $signed({1'b0, max})) begin
            r = max;
        end else begin
            r = p[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a
// single-Clk tick per rising edge; shared by the bullet and tank motion blocks.
module frame_tick (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_flush;

    // Synchroniser, edge history and arming; arming waits until the pipe holds
    // real samples and has seen frame_clk low, so a strobe already high at
    // reset release does not count as an edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_flush <= 2'b00;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_flush <= {r_flush[0], 1'b1};
            if (r_flush[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end

    assign tick = r_sync2 & ~r_prev & r_armed;

endmodule

// File: rtl/bullet_ctrl.sv
// Single-bullet controller: spawns at the tank centre on fire, flies with
// wall/screen-edge reflections, ends on tank hit, expiry or bounce limit.
module bullet_ctrl
    import tank_pkg::*;
#(
    parameter int BULLET_STEP     = 2,
    parameter int LIFE_FRAMES     = 240,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int MAX_BOUNCES     = 3,
    parameter int SPAWN_OFS       = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [9:0] X_Tank,
    input  logic [9:0] Y_Tank,
    input  logic [1:0] Dir,
    input  logic       Hit_X,
    input  logic       Hit_Y,
    input  logic       Hit_Tank,
    output logic [9:0] X_Bullet,
    output logic [9:0] Y_Bullet,
    output logic       Bullet_Active,
    output logic       Bullet_Kill,
    output logic [1:0] Bounce_Count
);

    localparam logic [9:0]  STEP       = BULLET_STEP[9:0];
    localparam logic [9:0]  OFS        = SPAWN_OFS[9:0];
    localparam logic [15:0] LIFE_INIT  = LIFE_FRAMES[15:0];
    localparam logic [15:0] COOL_INIT  = COOLDOWN_FRAMES[15:0];
    localparam logic [1:0]  BOUNCE_MAX = MAX_BOUNCES[1:0];

    bullet_state_t r_state, w_state_n;
    logic [9:0]  r_x, r_y, r_vx, r_vy;
    logic [9:0]  w_x_n, w_y_n, w_vx_n, w_vy_n;
    logic [1:0]  r_bounce, w_bounce_n;
    logic [15:0] r_life, w_life_n, r_cool, w_cool_n;
    logic        r_kill, w_kill_n, r_active, w_active_n;
    logic        w_tick;

    logic signed [10:0] w_nx, w_ny, w_bx, w_by;
    logic        w_edge_x, w_edge_y, w_flip_x, w_flip_y, w_hit;
    logic [9:0]  w_vx_b, w_vy_b;

    frame_tick u_frame_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (w_tick)
    );

    // Straight-line candidate decides edges; a bounce moves by the reflected velocity.
    assign w_nx     = $signed({1'b0, r_x}) + $signed({r_vx[9], r_vx});
    assign w_ny     = $signed({1'b0, r_y}) + $signed({r_vy[9], r_vy});
    assign w_edge_x = (w_nx < 11'sd0) || (w_nx > $signed({1'b0, SCREEN_X_MAX}));
    assign w_edge_y = (w_ny < 11'sd0) || (w_ny > $signed({1'b0, SCREEN_Y_MAX}));
    assign w_flip_x = Hit_X || w_edge_x;
    assign w_flip_y = Hit_Y || w_edge_y;
    assign w_hit    = w_flip_x || w_flip_y;
    assign w_vx_b   = w_flip_x ? negate(r_vx) : r_vx;
    assign w_vy_b   = w_flip_y ? negate(r_vy) : r_vy;
    assign w_bx     = $signed({1'b0, r_x}) + $signed({w_vx_b[9], w_vx_b});
    assign w_by     = $signed({1'b0, r_y}) + $signed({w_vy_b[9], w_vy_b});

    // Next-state and datapath decisions; nothing changes except on a tick.
    always_comb begin
        w_state_n  = r_state;
        w_x_n      = r_x;
        w_y_n      = r_y;
        w_vx_n     = r_vx;
        w_vy_n     = r_vy;
        w_bounce_n = r_bounce;
        w_life_n   = r_life;
        w_cool_n   = r_cool;
        w_kill_n   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_tick && fire) begin
                    w_x_n      = X_Tank + OFS;
                    w_y_n      = Y_Tank + OFS;
                    w_bounce_n = 2'd0;
                    w_life_n   = LIFE_INIT;
                    w_state_n  = FLY;
                    case (dir_t'(Dir))
                        UP:      begin w_vx_n = 10'd0;        w_vy_n = negate(STEP); end
                        RIGHT:   begin w_vx_n = STEP;         w_vy_n = 10'd0;        end
                        DOWN:    begin w_vx_n = 10'd0;        w_vy_n = STEP;         end
                        LEFT:    begin w_vx_n = negate(STEP); w_vy_n = 10'd0;        end
                        default: begin w_vx_n = 10'd0;        w_vy_n = 10'd0;        end
                    endcase
                end else begin
                    w_state_n = IDLE;
                end
            end
            FLY: begin
                if (!w_tick) begin
                    w_state_n = FLY;
                end else if (Hit_Tank) begin
                    w_kill_n  = 1'b1;
                    w_cool_n  = COOL_INIT;
                    w_state_n = COOLDOWN;
                end else if (r_life == 16'd1) begin
                    w_cool_n  = COOL_INIT;
                    w_state_n = COOLDOWN;
                end else if (w_hit) begin
                    if (r_bounce == BOUNCE_MAX) begin
                        w_cool_n  = COOL_INIT;
                        w_state_n = COOLDOWN;
                    end else begin
                        w_vx_n     = w_vx_b;
                        w_vy_n     = w_vy_b;
                        w_x_n      = clamp_pos(w_bx, SCREEN_X_MAX);
                        w_y_n      = clamp_pos(w_by, SCREEN_Y_MAX);
                        w_bounce_n = r_bounce + 2'd1;
                        w_life_n   = r_life - 16'd1;
                    end
                end else begin
                    w_x_n    = w_nx[9:0];
                    w_y_n    = w_ny[9:0];
                    w_life_n = r_life - 16'd1;
                end
            end
            COOLDOWN: begin
                if (!w_tick) begin
                    w_state_n = COOLDOWN;
                end else if (r_cool <= 16'd1) begin
                    w_cool_n  = 16'd0;
                    w_state_n = IDLE;
                end else begin
                    w_cool_n = r_cool - 16'd1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
        w_active_n = (w_state_n == FLY);
    end

    // State, position, velocity and counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_x      <= 10'd0;
            r_y      <= 10'd0;
            r_vx     <= 10'd0;
            r_vy     <= 10'd0;
            r_bounce <= 2'd0;
            r_life   <= 16'd0;
            r_cool   <= 16'd0;
            r_kill   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_vx     <= w_vx_n;
            r_vy     <= w_vy_n;
            r_bounce <= w_bounce_n;
            r_life   <= w_life_n;
            r_cool   <= w_cool_n;
            r_kill   <= w_kill_n;
            r_active <= w_active_n;
        end
    end

    assign X_Bullet      = r_x;
    assign Y_Bullet      = r_y;
    assign Bullet_Active = r_active;
    assign Bullet_Kill   = r_kill;
    assign Bounce_Count  = r_bounce;

endmodule
